// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes (also used by the ALU decoder) and
// the sequencing FSM states.
package alu_pkg;

    localparam int ALU_CTRL_W = 4;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

    function automatic logic is_shift_op(input logic [ALU_CTRL_W-1:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Iterative one-bit-per-cycle shifter with a down-counter. The owner loads it,
// steps it, and captures 'shifted' in the cycle where 'last' is high.
module alu_shifter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   amt,
    input  logic             left_in,
    input  logic             arith_in,
    output logic [WIDTH-1:0] shifted,
    output logic             last
);

    logic [WIDTH-1:0] data_reg;
    logic [SHW-1:0]   count_reg;
    logic             left_reg;
    logic             fill_reg;

    // One-bit step of the held value; right shifts fill with the bit captured at load.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign shifted[gi] = left_reg ? 1'b0 : data_reg[gi+1];
            end else if (gi == WIDTH-1) begin : g_msb
                assign shifted[gi] = left_reg ? data_reg[gi-1] : fill_reg;
            end else begin : g_mid
                assign shifted[gi] = left_reg ? data_reg[gi-1] : data_reg[gi+1];
            end
        end
    endgenerate

    assign last = (count_reg == SHW'(1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_reg  <= '0;
            count_reg <= '0;
            left_reg  <= 1'b0;
            fill_reg  <= 1'b0;
        end else if (load) begin
            data_reg  <= din;
            count_reg <= amt;
            left_reg  <= left_in;
            fill_reg  <= arith_in & din[WIDTH-1];
        end else if (step) begin
            data_reg  <= shifted;
            count_reg <= count_reg - SHW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Execute-stage ALU: single-cycle logic/arithmetic, iterative shifts, and a
// valid/ready handshake on both sides so the control unit can stall on shifts.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ALU_CTRL_W-1:0] ALUControl,
    input  logic [WIDTH-1:0]      SrcA,
    input  logic [WIDTH-1:0]      SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      ALUResult,
    output logic                  Zero,
    output logic                  Overflow
);

    alu_state_t       state_reg, state_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             zero_reg, zero_next;
    logic             ovf_reg, ovf_next;

    logic [SHW-1:0]   shamt;
    logic             shift_op;
    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             add_ovf;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    logic             sh_load;
    logic             sh_step;
    logic [WIDTH-1:0] sh_shifted;
    logic             sh_last;

    assign shamt    = SrcB[SHW-1:0];
    assign shift_op = is_shift_op(ALUControl);

    // SLT and SLTU reuse the subtractor: A + ~B + 1.
    assign is_sub   = (ALUControl == ALU_SUB) || (ALUControl == ALU_SLT) ||
                      (ALUControl == ALU_SLTU);
    assign b_eff    = is_sub ? ~SrcB : SrcB;
    assign add_full = {1'b0, SrcA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    assign sum      = add_full[WIDTH-1:0];
    assign carry    = add_full[WIDTH];
    assign add_ovf  = (SrcA[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ALUControl)
            ALU_AND:  alu_res = SrcA & SrcB;
            ALU_OR:   alu_res = SrcA | SrcB;
            ALU_XOR:  alu_res = SrcA ^ SrcB;
            ALU_ADD,
            ALU_SUB: begin
                alu_res = sum;
                alu_ovf = add_ovf;
            end
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ~carry};
            // Only reached through the single-cycle path when the amount is zero.
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  alu_res = SrcA;
            default:  alu_res = '0;
        endcase
    end

    alu_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (sh_load),
        .step     (sh_step),
        .din      (SrcA),
        .amt      (shamt),
        .left_in  (ALUControl == ALU_SLL),
        .arith_in (ALUControl == ALU_SRA),
        .shifted  (sh_shifted),
        .last     (sh_last)
    );

    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        zero_next   = zero_reg;
        ovf_next    = ovf_reg;
        sh_load     = 1'b0;
        sh_step     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    if (shift_op && (shamt != '0)) begin
                        sh_load    = 1'b1;
                        state_next = SHIFT;
                    end else begin
                        result_next = alu_res;
                        zero_next   = (alu_res == '0);
                        ovf_next    = alu_ovf;
                        state_next  = DONE;
                    end
                end
            end
            SHIFT: begin
                sh_step = 1'b1;
                if (sh_last) begin
                    result_next = sh_shifted;
                    zero_next   = (sh_shifted == '0);
                    ovf_next    = 1'b0;
                    state_next  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            result_reg <= '0;
            zero_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            zero_reg   <= zero_next;
            ovf_reg    <= ovf_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign ALUResult = result_reg;
    assign Zero      = zero_reg;
    assign Overflow  = ovf_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: known-answer table, randomized ops against a
// behavioural model, stall, mid-shift reset and back-to-back throughput.
module tb_alu_seq;

    localparam int W = 32;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    ALUControl;
    logic [W-1:0]  SrcA;
    logic [W-1:0]  SrcB;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  ALUResult;
    logic          Zero;
    logic          Overflow;

    int errors = 0;
    int checks = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .Overflow   (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: plain SV arithmetic. lat = clock edges after the
    // accept edge before out_valid is seen (0 means the very next cycle).
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] r,
                                  output logic z, output logic o, output int lat);
        int     amt;
        longint s;
        amt = int'(b % W);
        r   = '0;
        o   = 1'b0;
        lat = 0;
        s   = 0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: begin
                r = a + b;
                s = longint'($signed(a)) + longint'($signed(b));
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd3: begin
                r = a - b;
                s = longint'($signed(a)) - longint'($signed(b));
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd4: r = a ^ b;
            4'd5: begin r = a << amt; lat = amt; end
            4'd6: begin r = a >> amt; lat = amt; end
            4'd7: begin r = $unsigned($signed(a) >>> amt); lat = amt; end
            4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: r = (a < b) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        z = (r == '0);
    endfunction

    // Issue one op from IDLE, measure latency, check outputs, then drain it.
    task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_r,
                          input logic exp_z, input logic exp_o, input int exp_lat);
        int lat;
        bit ready_leak;
        lat = 0;
        ready_leak = 0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready_before_accept got=%b want=1", name, in_ready);
        end
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        while (out_valid !== 1'b1 && lat < 64) begin
            if (in_ready !== 1'b0) ready_leak = 1;
            @(posedge clk); #1;
            lat++;
        end
        if (out_valid === 1'b1 && in_ready !== 1'b0) ready_leak = 1;
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency got=%0d want=%0d edges after accept", name, lat, exp_lat);
        end
        checks++;
        if (ready_leak) begin
            errors++;
            $display("FAIL %s in_ready_busy got=1 want=0", name);
        end
        checks++;
        if (ALUResult !== exp_r || Zero !== exp_z || Overflow !== exp_o) begin
            errors++;
            $display("FAIL %s result got=%h z=%b o=%b want=%h z=%b o=%b",
                     name, ALUResult, Zero, Overflow, exp_r, exp_z, exp_o);
        end
        $display("op=%h a=%h b=%h -> %h z=%b o=%b lat=%0d (%s)",
                 op, a, b, ALUResult, Zero, Overflow, lat, name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s drain got out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        ALUControl = '0;
        SrcA       = '0;
        SrcB       = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ALUResult !== '0 ||
            Zero !== 1'b0 || Overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got ov=%b ir=%b r=%h z=%b o=%b want 0 1 0 0 0",
                     out_valid, in_ready, ALUResult, Zero, Overflow);
        end
        $display("reset: ov=%b ir=%b r=%h z=%b o=%b", out_valid, in_ready, ALUResult, Zero, Overflow);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_known_answers();
        logic [3:0]   ops [12] = '{4'h2, 4'h3, 4'h8, 4'h9, 4'h8, 4'h7,
                                   4'h5, 4'h6, 4'hC, 4'h4, 4'h3, 4'h5};
        logic [W-1:0] as  [12] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                   32'h80000000, 32'h80000000, 32'd1, 32'hF0000000,
                                   32'h12345678, 32'hAAAA5555, 32'h80000000, 32'h80000001};
        logic [W-1:0] bs  [12] = '{32'd1, 32'd5, 32'd1, 32'd1, 32'h7FFFFFFF, 32'd31,
                                   32'd0, 32'h00000124, 32'd9, 32'hFFFF0000, 32'd1, 32'd1};
        logic [W-1:0] rs  [12] = '{32'h80000000, 32'd0, 32'd1, 32'd0, 32'd1, 32'hFFFFFFFF,
                                   32'd1, 32'h0F000000, 32'd0, 32'h55555555, 32'h7FFFFFFF, 32'd2};
        logic         zs  [12] = '{0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
        logic         os  [12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        int           ls  [12] = '{0, 0, 0, 0, 0, 31, 0, 4, 0, 0, 0, 1};
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("kat%0d", i), ops[i], as[i], bs[i], rs[i], zs[i], os[i], ls[i]);
        end
    endtask

    task automatic test_random();
        logic [3:0]   op;
        logic [W-1:0] a, b, r;
        logic         z, o;
        int           lat;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if (i % 5 == 0) b = 32'($urandom_range(0, 3));
            model(op, a, b, r, z, o, lat);
            run_op($sformatf("rand%0d", i), op, a, b, r, z, o, lat);
        end
    endtask

    task automatic test_stall();
        int  waited;
        bit  unstable;
        waited   = 0;
        unstable = 0;
        ALUControl = 4'h2;
        SrcA       = 32'd10;
        SrcB       = 32'd20;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && waited < 8) begin
            @(posedge clk); #1;
            waited++;
        end
        for (int c = 0; c < 10; c++) begin
            in_valid   = c[0];
            ALUControl = 4'h3;
            SrcA       = 32'($urandom);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || ALUResult !== 32'd30 ||
                Zero !== 1'b0 || Overflow !== 1'b0) unstable = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (unstable || out_valid !== 1'b1 || ALUResult !== 32'd30) begin
            errors++;
            $display("FAIL stall_hold got ov=%b r=%h want ov=1 r=%h", out_valid, ALUResult, 32'd30);
        end
        $display("stall: held r=%h ov=%b for 10 cycles", ALUResult, out_valid);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got ir=%b ov=%b want 1/0", in_ready, out_valid);
        end
        run_op("after_stall", 4'h1, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_reset_mid_shift();
        ALUControl = 4'h6;
        SrcA       = 32'hFFFFFFFF;
        SrcB       = 32'd20;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || ALUResult !== '0 ||
            Zero !== 1'b0 || Overflow !== 1'b0) begin
            errors++;
            $display("FAIL mid_shift_reset got ir=%b ov=%b r=%h z=%b want 1 0 0 0",
                     in_ready, out_valid, ALUResult, Zero);
        end
        $display("mid-shift reset: ir=%b ov=%b r=%h", in_ready, out_valid, ALUResult);
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL discarded_shift got ov=%b want 0", out_valid);
        end
        run_op("add_after_reset", 4'h2, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        localparam int N = 6;
        logic [W-1:0] exp_q[$];
        logic [W-1:0] r, e;
        logic         z, o;
        int           lat, sent, got, iter, last_iter;
        sent = 0; got = 0; iter = 0; last_iter = -1;
        out_ready  = 1'b1;
        ALUControl = 4'($urandom_range(0, 4));
        SrcA       = $urandom;
        SrcB       = $urandom;
        model(ALUControl, SrcA, SrcB, r, z, o, lat);
        exp_q.push_back(r);
        sent     = 1;
        in_valid = 1'b1;
        while (got < N && iter < 4 * N) begin
            @(posedge clk); #1;
            iter++;
            if (out_valid === 1'b1) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                checks++;
                if (ALUResult !== e) begin
                    errors++;
                    $display("FAIL b2b_result%0d got=%h want=%h", got, ALUResult, e);
                end
                $display("b2b: result %0d = %h at iter %0d", got, ALUResult, iter);
                got++;
                last_iter = iter;
            end
            if (in_ready === 1'b1 && sent < N) begin
                ALUControl = 4'($urandom_range(0, 4));
                SrcA       = $urandom;
                SrcB       = $urandom;
                model(ALUControl, SrcA, SrcB, r, z, o, lat);
                exp_q.push_back(r);
                sent++;
            end else if (in_ready !== 1'b1 && sent == N) begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (got !== N || last_iter !== 2 * N - 1) begin
            errors++;
            $display("FAIL b2b_throughput got=%0d results by iter %0d want=%0d by iter %0d",
                     got, last_iter, N, 2 * N - 1);
        end
    endtask

    initial begin
        test_reset();
        test_known_answers();
        test_random();
        test_stall();
        test_reset_mid_shift();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
